// File: rtl/mc_ctrl_fsm_ws.sv
// mc_ctrl_fsm_ws: multicycle ARM main control FSM with memory wait states, iterative multiply and undefined-instruction trap
//   clk, reset                      : clock, asynchronous active-high reset
//   Op, Funct, IsMul                : instruction decode fields
//   mem_ready                       : memory access requested this cycle completes this cycle
//   IRWrite .. ALUOp                : datapath write enables and controls
//   ALUSrcA, ALUSrcB, ResultSrc     : datapath mux selects
//   mem_req, MulStart, undef_trap   : memory request, multiplier start pulse, undefined-instruction pulse
//   state_o                         : current state encoding, for debug
module mc_ctrl_fsm_ws #(
  parameter int HAS_MUL = 1,
  parameter int MUL_LAT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       IsMul,
  input  logic       mem_ready,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       ALUOp,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       mem_req,
  output logic       MulStart,
  output logic       undef_trap,
  output logic [3:0] state_o
);
  localparam int CW = $clog2(MUL_LAT + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(MUL_LAT - 1);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
    MEMWR = 4'd5, EXECUTER = 4'd6, EXECUTEI = 4'd7, ALUWB = 4'd8, BRANCH = 4'd9,
    UNDEF = 4'd10, MULEX = 4'd11, MULWB = 4'd12
  } state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic unused_funct;
  assign unused_funct = ^Funct[4:1];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  always_comb begin
    state_d = FETCH;
    cnt_d   = '0;
    case (state_q)
      FETCH:    state_d = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (Op)
          2'b00:   state_d = IsMul ? (HAS_MUL != 0 ? MULEX : UNDEF) : (Funct[5] ? EXECUTEI : EXECUTER);
          2'b01:   state_d = MEMADR;
          2'b10:   state_d = BRANCH;
          default: state_d = UNDEF;
        endcase
        cnt_d = state_d == MULEX ? CNT_INIT : '0;
      end
      EXECUTER, EXECUTEI: state_d = ALUWB;
      MEMADR:   state_d = Funct[0] ? MEMRD : MEMWR;
      MEMRD:    state_d = mem_ready ? MEMWB : MEMRD;
      MEMWR:    state_d = mem_ready ? FETCH : MEMWR;
      MULEX: begin
        state_d = cnt_q == '0 ? MULWB : MULEX;
        cnt_d   = cnt_q == '0 ? '0 : cnt_q - 1'b1;
      end
      default:  state_d = FETCH;
    endcase
  end
  // Outputs are forced low for the whole reset window, not just after the first edge.
  always_comb begin
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    NextPC     = 1'b0;
    RegW       = 1'b0;
    MemW       = 1'b0;
    Branch     = 1'b0;
    ALUOp      = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    mem_req    = 1'b0;
    MulStart   = 1'b0;
    undef_trap = 1'b0;
    if (!reset)
      case (state_q)
        FETCH: begin
          mem_req   = 1'b1;
          IRWrite   = mem_ready;
          NextPC    = mem_ready;
          ALUSrcA   = 2'b01;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
        end
        DECODE: begin
          ALUSrcA   = 2'b01;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
        end
        EXECUTER: ALUOp = 1'b1;
        EXECUTEI: begin
          ALUOp   = 1'b1;
          ALUSrcB = 2'b01;
        end
        ALUWB:    RegW = 1'b1;
        MEMADR:   ALUSrcB = 2'b01;
        MEMRD: begin
          AdrSrc  = 1'b1;
          mem_req = 1'b1;
        end
        MEMWR: begin
          AdrSrc  = 1'b1;
          mem_req = 1'b1;
          MemW    = 1'b1;
        end
        MEMWB: begin
          RegW      = 1'b1;
          ResultSrc = 2'b01;
        end
        BRANCH: begin
          Branch    = 1'b1;
          ALUSrcA   = 2'b10;
          ALUSrcB   = 2'b01;
          ResultSrc = 2'b10;
        end
        // The counter still holds its load value only in the first MULEX cycle.
        MULEX:    MulStart = cnt_q == CNT_INIT;
        MULWB: begin
          RegW      = 1'b1;
          ResultSrc = 2'b11;
        end
        UNDEF:    undef_trap = 1'b1;
        default: ;
      endcase
  end
  assign state_o = reset ? 4'd0 : state_q;
endmodule
